cache_miss_fsm: RTL and testbench
=================================

Name: cache_miss_fsm

Overview:
Parametrised, self-contained successor to the combinational cache control decode. It owns the cache state register and the line beat counter, drives I-cache/D-cache/RAM control each cycle, and stalls the CPU during misses. Line length is generic, and RAM transfers use a variable-latency req/ack handshake instead of a fixed beat count. It sits between the I/D cache_2way arrays, the RAM port and the pipeline stall logic.

Parameters:
WORDS_PER_LINE, 8, words per cache line; power of two, minimum 2
WORD_SEL_W, $clog2(WORDS_PER_LINE), width of word select and beat counter (derived, do not override)
BYTES_PER_WORD, 4, width of byte write enables

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
ic_read_in  in  1  CPU instruction fetch request
dc_read_in  in  1  CPU data load request
dc_write_in  in  1  CPU data store request
ic_word_sel_in  in  WORD_SEL_W  CPU fetch word offset
dc_word_sel_in  in  WORD_SEL_W  CPU data word offset
dc_byte_w_en_in  in  BYTES_PER_WORD  CPU store byte enables
ic_hit_in, ic_valid_in  in  1 each  I-cache lookup result
dc_hit_in, dc_valid_in, dc_dirty_in  in  1 each  D-cache lookup result (dirty refers to the victim)
ram_ack_in  in  1  RAM accepted/returned one word this cycle
ic_enable_out, ic_cmp_out, ic_write_out, ic_valid_out  out  1 each  I-cache control
ic_word_sel_out  out  WORD_SEL_W  I-cache word select
ic_byte_w_en_out  out  BYTES_PER_WORD  I-cache byte enables
dc_enable_out, dc_cmp_out, dc_write_out, dc_valid_out  out  1 each  D-cache control
dc_word_sel_out  out  WORD_SEL_W  D-cache word select
dc_byte_w_en_out  out  BYTES_PER_WORD  D-cache byte enables
ram_req_out  out  1  RAM beat request
ram_write_out  out  1  RAM beat is a write
ram_addr_sel_out  out  2  00 ic refill, 01 dc refill, 11 dc writeback
ic_src_dc_out  out  1  I-cache fill data comes from the D-cache rather than RAM
stall_out  out  1  CPU must hold its requests

Behaviour:
- Reset (async, rst_n=0): state=NORMAL, counter=0. Outputs decode as NORMAL: ram_req_out=0, ram_write_out=0, ic_src_dc_out=0, and stall_out follows the NORMAL miss rule. A reset mid-refill abandons the line; no partial line is ever marked valid.
- States: NORMAL, IC_MISS, DC_MISS, DC_WB, DBL_MISS, DBL_WB.
- NORMAL: enables and compare come straight from the CPU inputs (dc_enable = read|write, cmp=1, dc_write=dc_write_in). ram_req=0.
  - miss_d = dc_enable & ~(dc_hit & dc_valid); miss_i = ic_enable & ~(ic_hit & ic_valid).
  - stall_out = miss_d | miss_i.
  - Next state:
    - miss_d & miss_i: DBL_WB if dirty, else DBL_MISS.
    - miss_d only: DC_WB if dirty, else DC_MISS.
    - miss_i only: IC_MISS.
    - otherwise: NORMAL.
- Outside NORMAL: stall_out=1, CPU request inputs are ignored, and word_sel is driven from the counter.
- Beat rule: ram_req_out is held high with stable addr_sel, write and word_sel until ram_ack_in is sampled high. On the ack cycle:
  - refill states assert the target cache write with byte_w_en all ones;
  - the counter increments and wraps to 0 after WORDS_PER_LINE-1.
- Valid bit: valid_out=0 on every refill write except the last beat (counter==WORDS_PER_LINE-1), where valid_out=1.
- DC_WB / DBL_WB: D-cache is read (cmp=0), ram_write_out=1, addr_sel=11. After the last ack, go to DC_MISS / DBL_MISS respectively with counter=0.
- IC_MISS / DBL_MISS: I-cache is written (cmp=0), addr_sel=00. After the last beat, go to NORMAL / DC_MISS respectively.
- DC_MISS: D-cache is written, addr_sel=01. After the last beat, go to NORMAL.
- A ram_ack_in with ram_req_out low is ignored.
- Entering any miss state from NORMAL always sets counter=0.

Optional Feature:
Macro CACHE_IC_SNOOP_DC_EN.
- Defined: during IC_MISS/DBL_MISS the D-cache is looked up (cmp=1, word_sel=counter). On dc_hit&dc_valid, that beat is served from the D-cache: ram_req=0, ic_src_dc_out=1, ic_write=1, and the counter advances without waiting for ack.
- Undefined: the D-cache is not enabled in IC refill states, ic_src_dc_out is tied to 0, and every beat comes from RAM.

Decomposition:
- Package cache_pkg holds:
  - state enum (3 bits);
  - RAM_SEL_IC=2'b00, RAM_SEL_DC=2'b01, RAM_SEL_WB=2'b11.
- One sub-module, cache_beat_counter: WORD_SEL_W-bit counter with clear, advance and last-beat flag.

Test Plan:
1. WORDS_PER_LINE=8; ic_read=1, ic miss, ram_ack every 3rd cycle -> 8 ic_write pulses, each coincident with an ack; word_sel 0..7; valid_out=1 only on beat 7; back in NORMAL the cycle after, stall_out falling.
2. dc_write miss with dirty victim, ack every cycle -> 8 RAM writes (addr_sel=11), then 8 D-cache fills (addr_sel=01), then NORMAL. stall_out=1 for 16 cycles after the detect cycle.
3. Simultaneous ic and dc miss, dirty -> sequence DBL_WB(8) → DBL_MISS(8) → DC_MISS(8) → NORMAL.
4. rst_n low at beat 3 of IC_MISS -> immediate NORMAL, counter=0, no valid_out=1 write; a subsequent fetch miss restarts at word 0.
5. CACHE_IC_SNOOP_DC_EN defined, dc hits on words 2 and 5 during IC refill -> those beats have ram_req=0 and ic_src_dc_out=1 and complete in 1 cycle; the other 6 beats wait for ack.
6. WORDS_PER_LINE=2, ram_ack held high continuously -> refill completes in 2 cycles, and the counter wraps to 0 exactly once.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss controller.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL   = 3'd0,
        ST_IC_MISS  = 3'd1,
        ST_DC_MISS  = 3'd2,
        ST_DC_WB    = 3'd3,
        ST_DBL_MISS = 3'd4,
        ST_DBL_WB   = 3'd5
    } cache_state_e;

    localparam logic [1:0] RAM_SEL_IC = 2'b00;
    localparam logic [1:0] RAM_SEL_DC = 2'b01;
    localparam logic [1:0] RAM_SEL_WB = 2'b11;

    function automatic logic is_ic_refill(input cache_state_e st);
        return (st == ST_IC_MISS) || (st == ST_DBL_MISS);
    endfunction

endpackage

// File: rtl/cache_miss_fsm_if.sv
// CPU / cache-array / RAM signal bundle around the cache miss controller.
interface cache_miss_fsm_if #(
    parameter int WORDS_PER_LINE = 8,
    parameter int BYTES_PER_WORD = 4
);
    localparam int WORD_SEL_W = $clog2(WORDS_PER_LINE);

    logic                      ic_read_in;
    logic                      dc_read_in;
    logic                      dc_write_in;
    logic [WORD_SEL_W-1:0]     ic_word_sel_in;
    logic [WORD_SEL_W-1:0]     dc_word_sel_in;
    logic [BYTES_PER_WORD-1:0] dc_byte_w_en_in;
    logic                      ic_hit_in;
    logic                      ic_valid_in;
    logic                      dc_hit_in;
    logic                      dc_valid_in;
    logic                      dc_dirty_in;
    logic                      ram_ack_in;

    logic                      ic_enable_out;
    logic                      ic_cmp_out;
    logic                      ic_write_out;
    logic                      ic_valid_out;
    logic [WORD_SEL_W-1:0]     ic_word_sel_out;
    logic [BYTES_PER_WORD-1:0] ic_byte_w_en_out;
    logic                      dc_enable_out;
    logic                      dc_cmp_out;
    logic                      dc_write_out;
    logic                      dc_valid_out;
    logic [WORD_SEL_W-1:0]     dc_word_sel_out;
    logic [BYTES_PER_WORD-1:0] dc_byte_w_en_out;
    logic                      ram_req_out;
    logic                      ram_write_out;
    logic [1:0]                ram_addr_sel_out;
    logic                      ic_src_dc_out;
    logic                      stall_out;

    modport master (
        output ic_read_in, dc_read_in, dc_write_in, ic_word_sel_in, dc_word_sel_in,
               dc_byte_w_en_in, ic_hit_in, ic_valid_in, dc_hit_in, dc_valid_in,
               dc_dirty_in, ram_ack_in,
        input  ic_enable_out, ic_cmp_out, ic_write_out, ic_valid_out, ic_word_sel_out,
               ic_byte_w_en_out, dc_enable_out, dc_cmp_out, dc_write_out, dc_valid_out,
               dc_word_sel_out, dc_byte_w_en_out, ram_req_out, ram_write_out,
               ram_addr_sel_out, ic_src_dc_out, stall_out
    );

    modport slave (
        input  ic_read_in, dc_read_in, dc_write_in, ic_word_sel_in, dc_word_sel_in,
               dc_byte_w_en_in, ic_hit_in, ic_valid_in, dc_hit_in, dc_valid_in,
               dc_dirty_in, ram_ack_in,
        output ic_enable_out, ic_cmp_out, ic_write_out, ic_valid_out, ic_word_sel_out,
               ic_byte_w_en_out, dc_enable_out, dc_cmp_out, dc_write_out, dc_valid_out,
               dc_word_sel_out, dc_byte_w_en_out, ram_req_out, ram_write_out,
               ram_addr_sel_out, ic_src_dc_out, stall_out
    );

endinterface

// File: rtl/cache_beat_counter.sv
// Word-within-line beat counter; wraps naturally because the line length is a power of two.
module cache_beat_counter #(
    parameter  int WORDS_PER_LINE = 8,
    localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  adv,
    output logic [WORD_SEL_W-1:0] count,
    output logic                  last
);

    logic [WORD_SEL_W-1:0] count_r;

    // Beat counter register: clear has priority over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WORD_SEL_W{1'b0}};
        end else if (clr) begin
            count_r <= {WORD_SEL_W{1'b0}};
        end else if (adv) begin
            count_r <= count_r + WORD_SEL_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == WORD_SEL_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_miss_fsm.sv
// Cache miss controller: decodes I/D cache and RAM control, sequences writeback/refill, stalls the CPU.
// Optional macro CACHE_IC_SNOOP_DC_EN: I-cache refill beats may be served by a D-cache hit.
module cache_miss_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input logic            clk,
    input logic            rst_n,
    cache_miss_fsm_if.slave bus
);

    localparam int WORD_SEL_W = $clog2(WORDS_PER_LINE);
    localparam logic [BYTES_PER_WORD-1:0] BE_ONES = {BYTES_PER_WORD{1'b1}};
    localparam logic [BYTES_PER_WORD-1:0] BE_NONE = {BYTES_PER_WORD{1'b0}};

    cache_state_e          state_r;
    cache_state_e          next_state_s;
    logic [WORD_SEL_W-1:0] count_s;
    logic                  last_s;
    logic                  miss_i_s;
    logic                  miss_d_s;
    logic                  snoop_hit_s;
    logic                  req_s;
    logic                  beat_done_s;
    logic                  line_done_s;

    assign miss_i_s = bus.ic_read_in & ~(bus.ic_hit_in & bus.ic_valid_in);
    assign miss_d_s = (bus.dc_read_in | bus.dc_write_in) & ~(bus.dc_hit_in & bus.dc_valid_in);

`ifdef CACHE_IC_SNOOP_DC_EN
    assign snoop_hit_s = is_ic_refill(state_r) & bus.dc_hit_in & bus.dc_valid_in;
`else
    assign snoop_hit_s = 1'b0;
`endif

    // A beat completes on an ack while requesting, or immediately when the D-cache supplies it.
    assign req_s       = (state_r != ST_NORMAL) & ~snoop_hit_s;
    assign beat_done_s = (req_s & bus.ram_ack_in) | snoop_hit_s;
    assign line_done_s = beat_done_s & last_s;

    cache_beat_counter #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_r == ST_NORMAL),
        .adv  (beat_done_s),
        .count(count_s),
        .last (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_NORMAL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (miss_d_s & miss_i_s) begin
                    next_state_s = bus.dc_dirty_in ? ST_DBL_WB : ST_DBL_MISS;
                end else if (miss_d_s) begin
                    next_state_s = bus.dc_dirty_in ? ST_DC_WB : ST_DC_MISS;
                end else if (miss_i_s) begin
                    next_state_s = ST_IC_MISS;
                end else begin
                    next_state_s = ST_NORMAL;
                end
            end
            ST_IC_MISS:  next_state_s = line_done_s ? ST_NORMAL   : ST_IC_MISS;
            ST_DBL_MISS: next_state_s = line_done_s ? ST_DC_MISS  : ST_DBL_MISS;
            ST_DC_MISS:  next_state_s = line_done_s ? ST_NORMAL   : ST_DC_MISS;
            ST_DC_WB:    next_state_s = line_done_s ? ST_DC_MISS  : ST_DC_WB;
            ST_DBL_WB:   next_state_s = line_done_s ? ST_DBL_MISS : ST_DBL_WB;
            default:     next_state_s = ST_NORMAL;
        endcase
    end

    // Output decode; outside NORMAL both word selects follow the beat counter.
    always_comb begin
        bus.ic_enable_out    = 1'b0;
        bus.ic_cmp_out       = 1'b0;
        bus.ic_write_out     = 1'b0;
        bus.ic_valid_out     = 1'b0;
        bus.ic_word_sel_out  = count_s;
        bus.ic_byte_w_en_out = BE_NONE;
        bus.dc_enable_out    = 1'b0;
        bus.dc_cmp_out       = 1'b0;
        bus.dc_write_out     = 1'b0;
        bus.dc_valid_out     = 1'b0;
        bus.dc_word_sel_out  = count_s;
        bus.dc_byte_w_en_out = BE_NONE;
        bus.ram_req_out      = 1'b0;
        bus.ram_write_out    = 1'b0;
        bus.ram_addr_sel_out = RAM_SEL_IC;
        bus.ic_src_dc_out    = 1'b0;
        bus.stall_out        = 1'b1;
        case (state_r)
            ST_NORMAL: begin
                bus.ic_enable_out    = bus.ic_read_in;
                bus.ic_cmp_out       = 1'b1;
                bus.ic_word_sel_out  = bus.ic_word_sel_in;
                bus.dc_enable_out    = bus.dc_read_in | bus.dc_write_in;
                bus.dc_cmp_out       = 1'b1;
                bus.dc_write_out     = bus.dc_write_in;
                bus.dc_valid_out     = bus.dc_write_in;
                bus.dc_word_sel_out  = bus.dc_word_sel_in;
                bus.dc_byte_w_en_out = bus.dc_byte_w_en_in;
                bus.stall_out        = miss_i_s | miss_d_s;
            end
            ST_IC_MISS, ST_DBL_MISS: begin
                bus.ic_enable_out    = 1'b1;
                bus.ic_write_out     = beat_done_s;
                bus.ic_valid_out     = line_done_s;
                bus.ic_byte_w_en_out = beat_done_s ? BE_ONES : BE_NONE;
                bus.ram_req_out      = req_s;
                bus.ram_addr_sel_out = RAM_SEL_IC;
                bus.ic_src_dc_out    = snoop_hit_s;
`ifdef CACHE_IC_SNOOP_DC_EN
                bus.dc_enable_out    = 1'b1;
                bus.dc_cmp_out       = 1'b1;
`endif
            end
            ST_DC_MISS: begin
                bus.dc_enable_out    = 1'b1;
                bus.dc_write_out     = beat_done_s;
                bus.dc_valid_out     = line_done_s;
                bus.dc_byte_w_en_out = beat_done_s ? BE_ONES : BE_NONE;
                bus.ram_req_out      = req_s;
                bus.ram_addr_sel_out = RAM_SEL_DC;
            end
            ST_DC_WB, ST_DBL_WB: begin
                bus.dc_enable_out    = 1'b1;
                bus.ram_req_out      = req_s;
                bus.ram_write_out    = 1'b1;
                bus.ram_addr_sel_out = RAM_SEL_WB;
            end
            default: begin
                bus.stall_out        = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Bench for cache_miss_fsm: a phase-queue model checked every cycle plus directed literal checks.
// Covers CACHE_IC_SNOOP_DC_EN when that macro is defined for the build.
module tb_cache_miss_fsm;

    localparam int WPL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_miss_fsm_if #(.WORDS_PER_LINE(8), .BYTES_PER_WORD(4)) bus ();
    cache_miss_fsm_if #(.WORDS_PER_LINE(2), .BYTES_PER_WORD(4)) bus2 ();

    cache_miss_fsm #(.WORDS_PER_LINE(8), .BYTES_PER_WORD(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    cache_miss_fsm #(.WORDS_PER_LINE(2), .BYTES_PER_WORD(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of line transfers still to do
    typedef enum {P_WB, P_IC, P_DC} phase_t;
    phase_t plan[$];
    int     beat = 0;
    bit     m_mi, m_md, m_dirty, m_served;

    initial begin
        logic [10:0] e_ic, e_dc;
        logic [4:0]  e_ram;
        logic        e_stall, hit;
        logic [2:0]  ws;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                plan.delete();
                beat = 0;
            end
            m_served = 1'b0;
            m_mi = bus.ic_read_in & ~(bus.ic_hit_in & bus.ic_valid_in);
            m_md = (bus.dc_read_in | bus.dc_write_in) & ~(bus.dc_hit_in & bus.dc_valid_in);
            m_dirty = bus.dc_dirty_in;
            if (plan.size() == 0) begin
                e_ic    = {bus.ic_read_in, 1'b1, 1'b0, 1'b0, bus.ic_word_sel_in, 4'b0000};
                e_dc    = {bus.dc_read_in | bus.dc_write_in, 1'b1, bus.dc_write_in,
                           bus.dc_write_in, bus.dc_word_sel_in, bus.dc_byte_w_en_in};
                e_ram   = 5'b00000;
                e_stall = m_mi | m_md;
            end else begin
                ws = beat[2:0];
                e_stall = 1'b1;
                e_ic = {4'b0000, ws, 4'b0000};
                e_dc = {4'b0000, ws, 4'b0000};
                case (plan[0])
                    P_WB: begin
                        m_served = bus.ram_ack_in;
                        e_dc  = {4'b1000, ws, 4'b0000};
                        e_ram = {1'b1, 1'b1, 2'b11, 1'b0};
                    end
                    P_IC: begin
`ifdef CACHE_IC_SNOOP_DC_EN
                        hit  = bus.dc_hit_in & bus.dc_valid_in;
                        e_dc = {4'b1100, ws, 4'b0000};
`else
                        hit  = 1'b0;
`endif
                        m_served = hit | bus.ram_ack_in;
                        e_ic  = {2'b10, m_served, m_served && (beat == WPL - 1), ws,
                                 m_served ? 4'b1111 : 4'b0000};
                        e_ram = {~hit, 1'b0, 2'b00, hit};
                    end
                    default: begin
                        m_served = bus.ram_ack_in;
                        e_dc  = {2'b10, m_served, m_served && (beat == WPL - 1), ws,
                                 m_served ? 4'b1111 : 4'b0000};
                        e_ram = {1'b1, 1'b0, 2'b01, 1'b0};
                    end
                endcase
            end
            check("icache_ctl", 32'({bus.ic_enable_out, bus.ic_cmp_out, bus.ic_write_out,
                  bus.ic_valid_out, bus.ic_word_sel_out, bus.ic_byte_w_en_out}), 32'(e_ic));
            check("dcache_ctl", 32'({bus.dc_enable_out, bus.dc_cmp_out, bus.dc_write_out,
                  bus.dc_valid_out, bus.dc_word_sel_out, bus.dc_byte_w_en_out}), 32'(e_dc));
            check("ram_ctl", 32'({bus.ram_req_out, bus.ram_write_out, bus.ram_addr_sel_out,
                  bus.ic_src_dc_out}), 32'(e_ram));
            check("stall", 32'(bus.stall_out), 32'(e_stall));
            @(posedge clk);
            if (rst_n) begin
                if (plan.size() == 0) begin
                    if (m_md && m_dirty) plan.push_back(P_WB);
                    if (m_mi) plan.push_back(P_IC);
                    if (m_md) plan.push_back(P_DC);
                    beat = 0;
                end else if (m_served) begin
                    beat++;
                    if (beat == WPL) begin
                        beat = 0;
                        void'(plan.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus
    int n_stall, n_icw, n_icv, n_wb, n_dcf, n_dcv, n_src, n_ic_ram, n_bad;
    int first_ic, first_dc, last_wb, first_ic_ws, src_mask;
    bit snoop_mode = 1'b0;

    task automatic idle();
        bus.ic_read_in = 1'b0;      bus.dc_read_in = 1'b0;     bus.dc_write_in = 1'b0;
        bus.ic_word_sel_in = 3'd0;  bus.dc_word_sel_in = 3'd0; bus.dc_byte_w_en_in = 4'b0000;
        bus.ic_hit_in = 1'b0;       bus.ic_valid_in = 1'b1;    bus.dc_hit_in = 1'b0;
        bus.dc_valid_in = 1'b1;     bus.dc_dirty_in = 1'b0;    bus.ram_ack_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one miss from its detect cycle until stall drops, tallying observed activity.
    task automatic run_miss(input int period, input int exp_ic, input int exp_dc, input int budget);
        int cyc;
        bit done;
        n_stall = 0; n_icw = 0; n_icv = 0; n_wb = 0; n_dcf = 0; n_dcv = 0;
        n_src = 0; n_ic_ram = 0; n_bad = 0; src_mask = 0;
        first_ic = -1; first_dc = -1; last_wb = -1; first_ic_ws = -1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            bus.ram_ack_in = ((cyc % period) == (period - 1));
            if (snoop_mode)
                bus.dc_hit_in = bus.stall_out &&
                                (bus.dc_word_sel_out == 3'd2 || bus.dc_word_sel_out == 3'd5);
            @(negedge clk);
            if (cyc > 0 && !bus.stall_out) begin
                done = 1'b1;
            end else begin
                if (bus.stall_out) n_stall++;
                if (bus.ic_write_out) begin
                    if (first_ic < 0) begin
                        first_ic = cyc;
                        first_ic_ws = int'(bus.ic_word_sel_out);
                    end
                    if (int'(bus.ic_word_sel_out) != n_icw) n_bad++;
                    n_icw++;
                    if (bus.ic_valid_out) n_icv++;
                    if (bus.ic_src_dc_out) begin
                        n_src++;
                        src_mask |= (1 << bus.ic_word_sel_out);
                    end else if (bus.ram_req_out && bus.ram_ack_in) n_ic_ram++;
                    else n_bad++;
                end
                if (bus.ram_req_out && bus.ram_write_out && bus.ram_ack_in &&
                    bus.ram_addr_sel_out == 2'b11) begin
                    n_wb++;
                    last_wb = cyc;
                end
                if (bus.dc_write_out && !bus.dc_cmp_out) begin
                    if (first_dc < 0) first_dc = cyc;
                    if (int'(bus.dc_word_sel_out) != n_dcf) n_bad++;
                    if (!(bus.ram_req_out && bus.ram_ack_in && bus.ram_addr_sel_out == 2'b01)) n_bad++;
                    n_dcf++;
                    if (bus.dc_valid_out) n_dcv++;
                end
                step();
                cyc++;
                if (exp_ic > 0 && n_icw == exp_ic) bus.ic_hit_in = 1'b1;
                if (exp_dc > 0 && n_dcf == exp_dc) begin
                    bus.dc_hit_in = 1'b1;
                    bus.dc_dirty_in = 1'b0;
                end
            end
        end
        check("miss_completes", 32'(done), 32'd1);
        check("beat_order_and_ack", 32'(n_bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus2.ic_read_in = 1'b0;     bus2.dc_read_in = 1'b0;    bus2.dc_write_in = 1'b0;
        bus2.ic_word_sel_in = 1'b0; bus2.dc_word_sel_in = 1'b0; bus2.dc_byte_w_en_in = 4'b0000;
        bus2.ic_hit_in = 1'b0;      bus2.ic_valid_in = 1'b1;   bus2.dc_hit_in = 1'b0;
        bus2.dc_valid_in = 1'b1;    bus2.dc_dirty_in = 1'b0;   bus2.ram_ack_in = 1'b0;
        #12;
        check("reset_ram_req", 32'(bus.ram_req_out), 32'd0);
        check("reset_ram_write", 32'(bus.ram_write_out), 32'd0);
        check("reset_src_dc", 32'(bus.ic_src_dc_out), 32'd0);
        check("reset_stall_idle", 32'(bus.stall_out), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: fetch miss, ack every third cycle
        bus.ic_read_in = 1'b1;
        run_miss(3, 8, 0, 60);
        check("t1_ic_writes", 32'(n_icw), 32'd8);
        check("t1_ic_writes_on_ack", 32'(n_ic_ram), 32'd8);
        check("t1_valid_beats", 32'(n_icv), 32'd1);
        check("t1_first_word", 32'(first_ic_ws), 32'd0);
        check("t1_stall_cycles", 32'(n_stall), 32'd24);
        step();
        idle();
        step();

        // 2: dirty store miss, ack every cycle
        bus.dc_write_in = 1'b1; bus.dc_word_sel_in = 3'd3; bus.dc_byte_w_en_in = 4'b0101;
        bus.dc_dirty_in = 1'b1;
        run_miss(1, 0, 8, 40);
        check("t2_wb_beats", 32'(n_wb), 32'd8);
        check("t2_last_wb_cycle", 32'(last_wb), 32'd8);
        check("t2_dc_fills", 32'(n_dcf), 32'd8);
        check("t2_first_fill_cycle", 32'(first_dc), 32'd9);
        check("t2_dc_valid_beats", 32'(n_dcv), 32'd1);
        check("t2_stall_cycles", 32'(n_stall), 32'd17);
        step();
        idle();
        step();

        // 3: double miss with dirty victim
        bus.ic_read_in = 1'b1; bus.dc_read_in = 1'b1; bus.dc_dirty_in = 1'b1;
        run_miss(1, 8, 8, 50);
        check("t3_wb_beats", 32'(n_wb), 32'd8);
        check("t3_last_wb_cycle", 32'(last_wb), 32'd8);
        check("t3_first_ic_cycle", 32'(first_ic), 32'd9);
        check("t3_first_dc_cycle", 32'(first_dc), 32'd17);
        check("t3_ic_dc_fills", 32'(n_icw + n_dcf), 32'd16);
        check("t3_stall_cycles", 32'(n_stall), 32'd25);
        step();
        idle();
        step();

        // 4: reset at beat 3 of a fetch refill
        bus.ic_read_in = 1'b1; bus.ic_word_sel_in = 3'd5;
        n_icw = 0; n_icv = 0;
        for (int c = 0; c < 4; c++) begin
            bus.ram_ack_in = 1'b1;
            @(negedge clk);
            if (bus.ic_write_out) n_icw++;
            if (bus.ic_valid_out) n_icv++;
            step();
        end
        bus.ram_ack_in = 1'b0;
        check("t4_at_beat3", 32'(bus.ic_word_sel_out), 32'd3);
        rst_n = 1'b0;
        #2;
        check("t4_reset_no_req", 32'(bus.ram_req_out), 32'd0);
        check("t4_reset_normal_ws", 32'(bus.ic_word_sel_out), 32'd5);
        check("t4_partial_writes", 32'(n_icw), 32'd3);
        check("t4_no_valid", 32'(n_icv), 32'd0);
        step();
        rst_n = 1'b1;
        run_miss(1, 8, 0, 40);
        check("t4_restart_word", 32'(first_ic_ws), 32'd0);
        check("t4_restart_writes", 32'(n_icw), 32'd8);
        check("t4_restart_valid", 32'(n_icv), 32'd1);
        check("t4_restart_stall", 32'(n_stall), 32'd9);
        step();
        idle();
        step();

`ifdef CACHE_IC_SNOOP_DC_EN
        // 5: D-cache serves words 2 and 5 of an I-cache refill
        bus.ic_read_in = 1'b1;
        snoop_mode = 1'b1;
        run_miss(3, 8, 0, 60);
        snoop_mode = 1'b0;
        check("t5_ic_writes", 32'(n_icw), 32'd8);
        check("t5_snoop_beats", 32'(n_src), 32'd2);
        check("t5_snoop_words", 32'(src_mask), 32'h24);
        check("t5_ram_beats", 32'(n_ic_ram), 32'd6);
        check("t5_valid_beats", 32'(n_icv), 32'd1);
        step();
        idle();
        step();
`endif

        // 6: two-word line, ack held high; second refill proves the counter wrapped to 0
        bus2.ic_read_in = 1'b1;
        bus2.ram_ack_in = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            check("t6_detect", 32'({bus2.stall_out, bus2.ic_write_out}), 32'b10);
            step();
            @(negedge clk);
            check("t6_beat0", 32'({bus2.ic_write_out, bus2.ic_valid_out, bus2.ic_word_sel_out,
                  bus2.ram_req_out}), 32'b1001);
            step();
            @(negedge clk);
            check("t6_beat1", 32'({bus2.ic_write_out, bus2.ic_valid_out, bus2.ic_word_sel_out,
                  bus2.ram_req_out}), 32'b1111);
            step();
            bus2.ic_hit_in = 1'b1;
            @(negedge clk);
            check("t6_done", 32'({bus2.stall_out, bus2.ic_write_out, bus2.ram_req_out}), 32'b000);
            step();
            bus2.ic_hit_in = 1'b0;
        end
        bus2.ic_read_in = 1'b0;
        bus2.ram_ack_in = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
